// File: rtl/matrix_pkg.sv
// Shared widths, select codes and FSM encoding for the 3x3 matrix memory bank.
package matrix_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned DIM      = 3;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned NUM_MATS = 3;

  localparam int unsigned NUM_OPERANDS = 2 * DIM * DIM;
  localparam int unsigned NUM_RESULTS  = DIM * DIM;

  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_C    = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  localparam logic [IDX_W-1:0] DIM_IDX = IDX_W'(DIM);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIM - 1);

  typedef enum logic [1:0] {
    StLoad,
    StReady,
    StDump
  } state_e;

endpackage

// File: rtl/matrix_store.sv
// 3xDIMxDIM element array: registered controller read, combinational dump read of C,
// load write into A/B and controller write into C.
module matrix_store
  import matrix_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        rd_sel_i,
  input  logic [IDX_W-1:0]  rd_row_i,
  input  logic [IDX_W-1:0]  rd_col_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic [IDX_W-1:0]  dmp_row_i,
  input  logic [IDX_W-1:0]  dmp_col_i,
  output logic [DATA_W-1:0] dmp_data_o,
  input  logic              ld_we_i,
  input  logic              ld_sel_i,
  input  logic [IDX_W-1:0]  ld_row_i,
  input  logic [IDX_W-1:0]  ld_col_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic              c_we_i,
  input  logic [IDX_W-1:0]  c_row_i,
  input  logic [IDX_W-1:0]  c_col_i,
  input  logic [DATA_W-1:0] c_data_i
);

  logic [DATA_W-1:0] mem_q [NUM_MATS][DIM][DIM];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_ok;

  assign rd_ok      = (rd_sel_i != SEL_NONE) && (rd_row_i < DIM_IDX) && (rd_col_i < DIM_IDX);
  assign rd_data_o  = rd_data_q;
  assign dmp_data_o = mem_q[SEL_C][dmp_row_i][dmp_col_i];

  // Read samples the array before this edge's writes land: read-before-write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
      for (int m = 0; m < NUM_MATS; m++) begin
        for (int r = 0; r < DIM; r++) begin
          for (int c = 0; c < DIM; c++) begin
            mem_q[m][r][c] <= '0;
          end
        end
      end
    end else begin
      rd_data_q <= rd_ok ? mem_q[rd_sel_i][rd_row_i][rd_col_i] : '0;
      if (ld_we_i) begin
        mem_q[{1'b0, ld_sel_i}][ld_row_i][ld_col_i] <= ld_data_i;
      end
      if (c_we_i) begin
        mem_q[SEL_C][c_row_i][c_col_i] <= c_data_i;
      end
    end
  end

endmodule

// File: rtl/matrix_memory_bank.sv
// Operand/result storage for the 3x3 matrix-multiply controller with host load
// (A then B) and dump (C) streams.
module matrix_memory_bank
  import matrix_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        matrix_select_i,
  input  logic [IDX_W-1:0]  row_i,
  input  logic [IDX_W-1:0]  col_i,
  input  logic              write_enable_i,
  input  logic [DATA_W-1:0] write_data_i,
  output logic [DATA_W-1:0] read_data_o,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ready_o,
  output logic              loaded_o,
  input  logic              dump_req_i,
  output logic              dump_valid_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  input  logic              dump_ready_i,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic              ld_mat_q, ld_mat_d;
  logic [IDX_W-1:0]  ld_row_q, ld_row_d;
  logic [IDX_W-1:0]  ld_col_q, ld_col_d;
  logic [IDX_W-1:0]  dp_row_q, dp_row_d;
  logic [IDX_W-1:0]  dp_col_q, dp_col_d;
  logic              dump_valid_q, dump_valid_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic              dump_last_q, dump_last_d;
  logic              err_q, err_d;

  logic              idx_ok;
  logic              c_we;
  logic              ld_we;
  logic              dp_is_last;
  logic [DATA_W-1:0] dmp_data;

  assign idx_ok     = (row_i < DIM_IDX) && (col_i < DIM_IDX);
  assign c_we       = write_enable_i && (matrix_select_i == SEL_C) && idx_ok;
  assign ld_we      = load_valid_i && (state_q == StLoad);
  assign dp_is_last = (dp_row_q == IDX_MAX) && (dp_col_q == IDX_MAX);

  matrix_store u_store (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_sel_i   (matrix_select_i),
    .rd_row_i   (row_i),
    .rd_col_i   (col_i),
    .rd_data_o  (read_data_o),
    .dmp_row_i  (dp_row_q),
    .dmp_col_i  (dp_col_q),
    .dmp_data_o (dmp_data),
    .ld_we_i    (ld_we),
    .ld_sel_i   (ld_mat_q),
    .ld_row_i   (ld_row_q),
    .ld_col_i   (ld_col_q),
    .ld_data_i  (load_data_i),
    .c_we_i     (c_we),
    .c_row_i    (row_i),
    .c_col_i    (col_i),
    .c_data_i   (write_data_i)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StLoad;
      ld_mat_q     <= 1'b0;
      ld_row_q     <= '0;
      ld_col_q     <= '0;
      dp_row_q     <= '0;
      dp_col_q     <= '0;
      dump_valid_q <= 1'b0;
      dump_data_q  <= '0;
      dump_last_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_mat_q     <= ld_mat_d;
      ld_row_q     <= ld_row_d;
      ld_col_q     <= ld_col_d;
      dp_row_q     <= dp_row_d;
      dp_col_q     <= dp_col_d;
      dump_valid_q <= dump_valid_d;
      dump_data_q  <= dump_data_d;
      dump_last_q  <= dump_last_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_mat_d     = ld_mat_q;
    ld_row_d     = ld_row_q;
    ld_col_d     = ld_col_q;
    dp_row_d     = dp_row_q;
    dp_col_d     = dp_col_q;
    dump_valid_d = dump_valid_q;
    dump_data_d  = dump_data_q;
    dump_last_d  = dump_last_q;
    err_d        = err_q
                 | (matrix_select_i == SEL_NONE) | !idx_ok
                 | (write_enable_i && !c_we);

    unique case (state_q)
      StLoad: begin
        if (load_valid_i) begin
          if (ld_col_q == IDX_MAX) begin
            ld_col_d = '0;
            if (ld_row_q == IDX_MAX) begin
              ld_row_d = '0;
              ld_mat_d = ~ld_mat_q;
              if (ld_mat_q) begin
                state_d = StReady;
              end
            end else begin
              ld_row_d = ld_row_q + 1'b1;
            end
          end else begin
            ld_col_d = ld_col_q + 1'b1;
          end
        end
      end
      StReady, StDump: begin
        // dp points at the next C element to register; READY launches beat 0.
        if ((state_q == StReady && dump_req_i) || (state_q == StDump && dump_ready_i)) begin
          if (state_q == StDump && dump_last_q) begin
            state_d      = StLoad;
            dump_valid_d = 1'b0;
            dump_last_d  = 1'b0;
            dp_row_d     = '0;
            dp_col_d     = '0;
          end else begin
            state_d      = StDump;
            dump_valid_d = 1'b1;
            dump_data_d  = dmp_data;
            dump_last_d  = dp_is_last;
            if (dp_col_q == IDX_MAX) begin
              dp_col_d = '0;
              dp_row_d = (dp_row_q == IDX_MAX) ? '0 : dp_row_q + 1'b1;
            end else begin
              dp_col_d = dp_col_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  assign load_ready_o = (state_q == StLoad);
  assign loaded_o     = (state_q != StLoad);
  assign dump_valid_o = dump_valid_q;
  assign dump_data_o  = dump_data_q;
  assign dump_last_o  = dump_last_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_matrix_memory_bank.sv
// Directed bench for matrix_memory_bank: load, controller read/write, dump streams and reset.
module tb_matrix_memory_bank;

  logic       clk;
  logic       rst;
  logic [1:0] sel;
  logic [1:0] row;
  logic [1:0] col;
  logic       we;
  logic [7:0] wdata;
  logic [7:0] read_data;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       loaded;
  logic       dump_req;
  logic       dump_valid;
  logic [7:0] dump_data;
  logic       dump_last;
  logic       dump_ready;
  logic       err;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  rq[$];
  logic [7:0]  dq[$];
  int          cyc;

  matrix_memory_bank dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .matrix_select_i (sel),
    .row_i           (row),
    .col_i           (col),
    .write_enable_i  (we),
    .write_data_i    (wdata),
    .read_data_o     (read_data),
    .load_valid_i    (load_valid),
    .load_data_i     (load_data),
    .load_ready_o    (load_ready),
    .loaded_o        (loaded),
    .dump_req_i      (dump_req),
    .dump_valid_o    (dump_valid),
    .dump_data_o     (dump_data),
    .dump_last_o     (dump_last),
    .dump_ready_i    (dump_ready),
    .err_o           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one controller access; the expected read value is scored one edge later.
  task automatic rw(input logic [1:0] s, input logic [1:0] r, input logic [1:0] c,
                    input logic w, input logic [7:0] d, input logic [7:0] exp);
    logic [7:0] e;
    sel = s; row = r; col = c; we = w; wdata = d;
    rq.push_back(exp);
    tick();
    we = 1'b0;
    e = rq.pop_front();
    check("read_data", {24'd0, read_data}, {24'd0, e});
  endtask

  task automatic load_all(input logic [7:0] base);
    load_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      load_data = base + 8'(i);
      if (i == 17) check("loaded_before_last", {31'd0, loaded}, 32'd0);
      tick();
    end
    load_valid = 1'b0;
    check("loaded_after_18", {31'd0, loaded}, 32'd1);
    check("load_ready_after_18", {31'd0, load_ready}, 32'd0);
  endtask

  task automatic c_fill(input logic [7:0] base);
    for (int i = 0; i < 9; i++) begin
      sel = 2'd2; row = 2'(i / 3); col = 2'(i % 3); we = 1'b1; wdata = base + 8'(i);
      tick();
    end
    we = 1'b0; sel = 2'd0; row = 2'd0; col = 2'd0;
  endtask

  // Streams a full dump with dump_ready following pat[cycle % 4]; expected beats come from dq.
  task automatic dump_run(input logic [3:0] pat, input int nbeats, output int cycles);
    int beats;
    logic [7:0] e;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    cycles = 0;
    beats  = 0;
    while (beats < nbeats && cycles < 100) begin
      dump_ready = pat[cycles % 4];
      if (dump_valid && dq.size() > 0) begin
        e = dq[0];
        check("dump_data", {24'd0, dump_data}, {24'd0, e});
        check("dump_last", {31'd0, dump_last}, {31'd0, beats == nbeats - 1});
        if (dump_ready) begin
          void'(dq.pop_front());
          beats++;
        end
      end
      tick();
      cycles++;
    end
    dump_ready = 1'b0;
    check("dump_beats", beats, nbeats);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 2'd0; row = 2'd0; col = 2'd0; we = 1'b0; wdata = '0;
    load_valid = 1'b0; load_data = '0; dump_req = 1'b0; dump_ready = 1'b0;
    tick();
    tick();
    check("rst_read_data", {24'd0, read_data}, 32'd0);
    check("rst_dump_valid", {31'd0, dump_valid}, 32'd0);
    check("rst_dump_data", {24'd0, dump_data}, 32'd0);
    check("rst_dump_last", {31'd0, dump_last}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_loaded", {31'd0, loaded}, 32'd0);
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    rst = 1'b0;

    load_all(8'd1);
    rw(2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 8'd1);
    rw(2'd0, 2'd1, 2'd2, 1'b0, 8'h00, 8'd6);
    rw(2'd1, 2'd0, 2'd0, 1'b0, 8'h00, 8'd10);
    rw(2'd1, 2'd2, 2'd1, 1'b0, 8'h00, 8'd17);
    check("err_before_bad", {31'd0, err}, 32'd0);
    rw(2'd3, 2'd0, 2'd0, 1'b0, 8'h00, 8'd0);
    check("err_after_sel3", {31'd0, err}, 32'd1);
    rw(2'd1, 2'd3, 2'd0, 1'b0, 8'h00, 8'd0);

    // Same-cycle read+write of C[1][1] returns the prior contents.
    rw(2'd2, 2'd1, 2'd1, 1'b1, 8'h5A, 8'h00);
    rw(2'd2, 2'd1, 2'd1, 1'b1, 8'h77, 8'h5A);
    rw(2'd2, 2'd1, 2'd1, 1'b0, 8'h00, 8'h77);
    sel = 2'd0; row = 2'd0; col = 2'd0;

    c_fill(8'h20);
    for (int i = 0; i < 9; i++) dq.push_back(8'h20 + 8'(i));
    dump_run(4'b1111, 9, cyc);
    check("dump_cycles_full_rate", cyc, 9);
    check("post_dump_valid", {31'd0, dump_valid}, 32'd0);
    check("post_dump_load_ready", {31'd0, load_ready}, 32'd1);
    check("post_dump_loaded", {31'd0, loaded}, 32'd0);

    load_all(8'h40);
    rw(2'd1, 2'd2, 2'd2, 1'b0, 8'h00, 8'h51);
    c_fill(8'h30);
    for (int i = 0; i < 9; i++) dq.push_back(8'h30 + 8'(i));
    dump_run(4'b1001, 9, cyc);
    check("dump_cycles_stalled", cyc, 17);
    check("post_stall_valid", {31'd0, dump_valid}, 32'd0);

    load_all(8'h60);
    c_fill(8'h50);
    dump_req = 1'b1; dump_ready = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("pre_rst_beat", {24'd0, dump_data}, {24'd0, 8'h50 + 8'(k)});
      tick();
    end
    check("beat4_valid", {31'd0, dump_valid}, 32'd1);
    check("beat4_data", {24'd0, dump_data}, 32'h54);
    rst = 1'b1; dump_ready = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, dump_valid}, 32'd0);
    check("mid_rst_load_ready", {31'd0, load_ready}, 32'd1);
    check("mid_rst_loaded", {31'd0, loaded}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    rw(2'd2, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00);
    rw(2'd2, 2'd1, 2'd1, 1'b0, 8'h00, 8'h00);

    // A write aimed at A is rejected and flags err.
    rw(2'd0, 2'd0, 2'd0, 1'b1, 8'h99, 8'h00);
    check("err_after_bad_write", {31'd0, err}, 32'd1);
    rw(2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_memory_bank.md
Name: matrix_memory_bank

Overview:
- Storage responder for the 3x3 matrix-multiply controller. Holds operand matrices A and B and result matrix C.
- Serves the controller's select/row/col read and write port with a 1-cycle registered read.
- Host side: a valid/ready load stream fills A then B; a valid/ready dump stream drains C after the controller finishes.

Parameters:
DATA_W, 8, element width in bits
DIM, 3, matrix dimension (rows = cols = DIM)
IDX_W, 2, row/col index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
matrix_select  in  2  controller target: 0=A, 1=B, 2=C, 3=none
row  in  IDX_W  controller row index
col  in  IDX_W  controller column index
write_enable  in  1  controller write strobe
write_data  in  DATA_W  controller write value
read_data  out  DATA_W  registered read of the addressed element
load_valid  in  1  host operand beat valid
load_data  in  DATA_W  host operand value
load_ready  out  1  bank accepting operand beats
loaded  out  1  A and B fully loaded; controller start permitted
dump_req  in  1  one-cycle request to stream out C
dump_valid  out  1  dump beat valid
dump_data  out  DATA_W  C element
dump_last  out  1  marks the final dump beat
dump_ready  in  1  host accepts the dump beat
err  out  1  sticky illegal-access flag

Behaviour:
- Reset (synchronous, active-high):
  - All 3*DIM*DIM entries cleared to 0.
  - read_data=0, dump_valid=0, dump_data=0, dump_last=0, err=0, loaded=0.
  - State=LOAD; load pointer, dump pointer and matrix counter all 0.
  - Reset mid-load or mid-dump abandons the transfer; the next cycle begins a fresh LOAD.
- Controller read:
  - Every cycle, read_data <= M[matrix_select][row][col], giving latency 1. The address presented in cycle N is valid after edge N+1.
  - select=3, or row/col >= DIM: read_data <= 0 and err sets.
  - Reads are read-before-write: a same-cycle write to the same entry returns the old value.
- Controller write:
  - Only matrix_select=2 with an in-range index writes C.
  - write_enable with select 0/1/3 or an out-of-range index is ignored and sets err.
  - Controller writes are accepted in any state.
- FSM states: LOAD, READY, DUMP.
- LOAD:
  - load_ready=1.
  - Each load_valid&&load_ready beat writes the load pointer in row-major order: A[0][0]..A[2][2], then B[0][0]..B[2][2].
  - After 2*DIM*DIM (18) beats: state goes to READY, loaded=1 from the next cycle, load_ready=0.
  - Beats with load_ready=0 are dropped.
- READY:
  - loaded=1.
  - dump_req goes to DUMP. On the same edge, dump_data <= C[0][0], dump_valid <= 1.
  - dump_req in LOAD or DUMP is ignored.
- DUMP:
  - C is streamed row-major, 9 beats.
  - While dump_valid && !dump_ready: dump_data and dump_last hold stable.
  - On a handshake, the next element is registered on the same edge, so a continuously held dump_ready yields 1 beat/cycle.
  - dump_last=1 on beat index DIM*DIM-1.
  - After the last handshake: dump_valid=0, state goes to LOAD, loaded=0, pointers reset. A and B are retained until overwritten; C is retained.
  - Each dump beat is sampled from C at the edge it is registered. A controller write to an already-dumped entry does not affect the stream.
- Pointer wrap: col 0..DIM-1, then row+1; the matrix counter increments after row DIM-1.
- err is cleared only by reset.

Decomposition:
- Package matrix_pkg holds:
  - DATA_W, DIM, IDX_W
  - SEL_A=0, SEL_B=1, SEL_C=2, SEL_NONE=3
  - FSM state encoding LOAD/READY/DUMP
  - NUM_OPERANDS = 2*DIM*DIM and NUM_RESULTS = DIM*DIM
- One sub-module: matrix_store.
  - 3xDIMxDIM register array.
  - One synchronous read port (controller).
  - One combinational read port (dump).
  - Two write ports: load into A/B, controller into C. They never collide by construction.

Test Plan:
- Reset, then load 18 beats of values 1..18 with load_valid held → loaded rises the cycle after beat 18; A[1][2]=6; B[0][0]=10.
- In READY, set select=1,row=2,col=1 → read_data=17 exactly one cycle later. Set select=3 → read_data=0 and err=1.
- Controller writes select=2,row=1,col=1,data=0x5A, then reads it back → 0x5A after 1 cycle.
- Same-cycle read+write of C[1][1] → old value returned.
- Fill C with 0x20..0x28, pulse dump_req, hold dump_ready=1 → 9 consecutive beats 0x20..0x28. dump_last on 0x28. State returns to LOAD and load_ready=1.
- Dump with dump_ready toggled 1,0,0,1 → beat held stable while stalled, no loss or duplication.
- Assert reset on dump beat 4 → next cycle dump_valid=0, load_ready=1, C reads 0.
